// File: rtl/rv32_pkg.sv
// Shared types for the RV32 pipeline control unit: FSM states, the
// enable/flush bundle, and the load-use hazard detector.
package rv32_pkg;

    typedef enum logic {
        PC_RUN      = 1'b0,
        PC_MEM_WAIT = 1'b1
    } pipe_ctrl_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mm_en;
        logic mm_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN    = 7'b11111_00;
    localparam pipe_ctrl_t CTRL_FREEZE = 7'b00000_00;

    // x0 is hardwired, so a load targeting it never creates a hazard.
    function automatic logic load_use_hazard(
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic       use_rs1, input logic use_rs2,
        input logic [4:0] rd, input logic we, input logic is_load
    );
        return is_load && we && (rd != 5'd0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: combinational stage
// enables/flushes, a dmem wait FSM with sticky timeout, and perf counters.
module pipe_ctrl_unit
    import rv32_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MAX_MEM_WAIT = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_we_i,
    input  logic             ex_is_load_i,
    input  logic             ex_redirect_i,
    input  logic             dmem_req_i,
    input  logic             dmem_rsp_i,
    input  logic             if_busy_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mm_en_o,
    output logic             mm_wb_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_timeout_o
);

    localparam int              WAIT_W   = (MAX_MEM_WAIT < 2) ? 1 : $clog2(MAX_MEM_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);
    localparam bit              TO_EN    = (MAX_MEM_WAIT != 0);

    pipe_ctrl_state_e  state_q, state_d, state_eff;
    logic [WAIT_W-1:0] wait_cnt_q, wait_inc;
    logic              timeout_q;
    logic              mem_freeze, load_use;
    pipe_ctrl_t        ctrl;

    // While reset is asserted the outputs follow RUN, whatever state_q holds.
    assign state_eff = rst_ni ? state_q : PC_RUN;

    assign mem_freeze = ((state_eff == PC_RUN) && dmem_req_i && !dmem_rsp_i) ||
                        ((state_eff == PC_MEM_WAIT) && !dmem_rsp_i);

    assign load_use = load_use_hazard(id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
                                      ex_rd_i, ex_we_i, ex_is_load_i);

    always_comb begin
        ctrl = CTRL_RUN;
        if (mem_freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (ex_redirect_i) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
        end else if (if_busy_i) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PC_RUN:      if (dmem_req_i && !dmem_rsp_i) state_d = PC_MEM_WAIT;
            PC_MEM_WAIT: if (dmem_rsp_i) state_d = PC_RUN;
            default:     state_d = PC_RUN;
        endcase
    end

    assign wait_inc = wait_cnt_q + 1'b1;

    // Only frozen MEM_WAIT cycles count; the response cycle ends the wait.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= PC_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == PC_RUN) begin
                wait_cnt_q <= '0;
            end else if (!dmem_rsp_i) begin
                if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_inc;
                if (TO_EN && (wait_inc == WAIT_MAX)) timeout_q <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (!rst_ni),
        .en_i  (!ctrl.pc_en),
        .q_o   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .clr_i (!rst_ni),
        .en_i  (!mem_freeze && ex_redirect_i),
        .q_o   (flush_cnt_o)
    );

    assign pc_en_o       = ctrl.pc_en;
    assign if_id_en_o    = ctrl.if_id_en;
    assign id_ex_en_o    = ctrl.id_ex_en;
    assign ex_mm_en_o    = ctrl.ex_mm_en;
    assign mm_wb_en_o    = ctrl.mm_wb_en;
    assign if_id_flush_o = ctrl.if_id_flush;
    assign id_ex_flush_o = ctrl.id_ex_flush;
    assign mem_timeout_o = timeout_q;

endmodule
